// File: rtl/add_pkg.sv
// Shared definitions for the serial adder/subtractor.
//   state_t   : FSM state encoding (2-bit)
//   cnt_width : width of a counter that must hold 0..n-1 (never less than 1 bit)
package add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// Ports:
//   i_a, i_b  CHUNK-bit operands
//   i_cin     carry into bit 0
//   o_sum     CHUNK-bit sum
//   o_cout    carry out of the top bit
//   o_cmsb    carry into the top bit (used for signed overflow)
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar k = 0; k < CHUNK; k++) begin : g_fa
    assign o_sum[k]   = i_a[k] ^ i_b[k] ^ w_c[k];
    assign w_c[k + 1] = (i_a[k] & i_b[k]) | (w_c[k] & (i_a[k] ^ i_b[k]));
  end

  assign o_cout = w_c[CHUNK];
  assign o_cmsb = w_c[CHUNK-1];

endmodule

// File: rtl/add_serial.sv
// Multi-cycle adder/subtractor: one CHUNK-bit adder reused WIDTH/CHUNK times,
// LSB chunk first, carry held in a register between chunks.
// Optional feature macro: ADD_SERIAL_FLAGS_EN adds zero/negative/overflow flags.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_in_valid, o_in_ready  operand handshake (i_a, i_b, i_sub, i_cin)
//   i_sub                   1: a - b, 0: a + b + cin (cin ignored for subtract)
//   o_out_valid, i_out_ready result handshake (o_sum, o_cout)
//   o_cout                  carry out of MSB (subtract: 1 = no borrow)
//   o_zr, o_ng, o_ovf       only with ADD_SERIAL_FLAGS_EN
//
// state | meaning
// IDLE  | ready for operands
// RUN   | adding one chunk per cycle
// DONE  | result held until consumer takes it
module add_serial
  import add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
`ifdef ADD_SERIAL_FLAGS_EN
  ,
  output logic             o_zr,
  output logic             o_ng,
  output logic             o_ovf
`endif
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             w_accept;
  logic             w_last;
  logic [CHUNK-1:0] w_chunk_sum;
  logic             w_chunk_cout;
  logic             w_chunk_cmsb;

  // Operands are shifted right each RUN cycle, so the adder always sees the low chunk.
  add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a    (r_a[CHUNK-1:0]),
    .i_b    (r_b[CHUNK-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_chunk_sum),
    .o_cout (w_chunk_cout),
    .o_cmsb (w_chunk_cmsb)
  );

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    w_accept    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      // Subtract as a + ~b + 1.
      r_a     <= i_a;
      r_b     <= i_sub ? ~i_b : i_b;
      r_carry <= i_sub | i_cin;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_carry <= w_chunk_cout;
      r_cnt   <= r_cnt + 1'b1;
      for (int k = 0; k < N; k++) begin
        if (r_cnt == CNT_W'(k)) r_sum[k*CHUNK +: CHUNK] <= w_chunk_sum;
      end
      if (w_last) r_cout <= w_chunk_cout;
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;

`ifdef ADD_SERIAL_FLAGS_EN
  logic [WIDTH-1:0] w_sum_final;
  logic             r_zr;
  logic             r_ng;
  logic             r_ovf;

  // Full result as it will look after the final chunk write.
  always_comb begin
    w_sum_final = r_sum;
    w_sum_final[WIDTH-CHUNK +: CHUNK] = w_chunk_sum;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_zr  <= 1'b0;
      r_ng  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (r_state == ST_RUN && w_last) begin
      r_zr  <= (w_sum_final == '0);
      r_ng  <= w_chunk_sum[CHUNK-1];
      r_ovf <= w_chunk_cmsb ^ w_chunk_cout;
    end
  end

  assign o_zr  = r_zr;
  assign o_ng  = r_ng;
  assign o_ovf = r_ovf;
`else
  logic w_unused_cmsb;
  assign w_unused_cmsb = w_chunk_cmsb;
`endif

endmodule
